// File: rtl/spis_pkg.sv
// Shared opcodes and FSM state encoding for the SPI slave bridge.
package spis_pkg;

  localparam logic [7:0] CMD_RD = 8'h10;
  localparam logic [7:0] CMD_WR = 8'h2F;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    DUMMY,
    RDATA,
    WAIT
  } state_e;

endpackage

// File: rtl/spis_sync.sv
// Brings sclk/ssn/sdin into the mclk domain.
// Provides edge strobes and an sdin copy aligned with them.
module spis_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic ssn,
  input  logic sdin,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ssn_rise,
  output logic ssn_fall,
  output logic sdin_s
);

  logic [SYNC_STG:0]   sclk_q, sclk_d;
  logic [SYNC_STG:0]   ssn_q, ssn_d;
  logic [SYNC_STG-1:0] sdin_q, sdin_d;

  always_comb begin
    sclk_d    = sclk_q << 1;
    sclk_d[0] = sclk;
    ssn_d     = ssn_q << 1;
    ssn_d[0]  = ssn;
    sdin_d    = sdin_q << 1;
    sdin_d[0] = sdin;
  end

  // Idle levels of sclk/ssn are high, so reset to 1 to avoid false edges
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q <= '1;
      ssn_q  <= '1;
      sdin_q <= '0;
    end else begin
      sclk_q <= sclk_d;
      ssn_q  <= ssn_d;
      sdin_q <= sdin_d;
    end
  end

  assign sclk_rise = sclk_q[SYNC_STG-1] & ~sclk_q[SYNC_STG];
  assign sclk_fall = ~sclk_q[SYNC_STG-1] & sclk_q[SYNC_STG];
  assign ssn_rise  = ssn_q[SYNC_STG-1] & ~ssn_q[SYNC_STG];
  assign ssn_fall  = ~ssn_q[SYNC_STG-1] & ssn_q[SYNC_STG];
  assign sdin_s    = sdin_q[SYNC_STG-1];

endmodule

// File: rtl/spis_reg_bridge.sv
// SPI slave front-end turning read/write frames into
// single 32-bit register-bus cycles.
module spis_reg_bridge
  import spis_pkg::*;
#(
  parameter int         SYNC_STG = 2,
  parameter logic [7:0] CMD_RD   = spis_pkg::CMD_RD,
  parameter logic [7:0] CMD_WR   = spis_pkg::CMD_WR
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic        sclk,
  input  logic        ssn,
  input  logic        sdin,
  output logic        sdout,
  output logic        reg_cs,
  output logic        reg_wr,
  output logic [31:0] reg_addr,
  output logic [3:0]  reg_be,
  output logic [31:0] reg_wdata,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack,
  output logic        spi_err
);

  logic sclk_rise, sclk_fall;
  logic ssn_rise, ssn_fall, sdin_s;

  state_e      state_q, state_d;
  logic [6:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] sh_q, sh_d, shin;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        cs_q, cs_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic [3:0]  be_q, be_d;

  spis_sync #(
    .SYNC_STG (SYNC_STG)
  ) u_sync (
    .clk       (mclk),
    .rst_n     (reset_n),
    .sclk      (sclk),
    .ssn       (ssn),
    .sdin      (sdin),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ssn_rise  (ssn_rise),
    .ssn_fall  (ssn_fall),
    .sdin_s    (sdin_s)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cs_d      = cs_q;
    wr_d      = wr_q;
    err_d     = 1'b0;
    be_d      = 4'hF;
    shin      = {sh_q[30:0], sdin_s};

    // Ack is honoured in any state; rdata only kept while in DUMMY
    if (cs_q && reg_ack) begin
      cs_d = 1'b0;
      if (state_q == DUMMY && !wr_q)
        sh_d = reg_rdata;
    end

    if (sclk_rise && state_q != IDLE && state_q != WAIT)
      bit_cnt_d = bit_cnt_q + 7'd1;

    unique case (state_q)
      IDLE: begin
        if (ssn_fall && !cs_q) begin
          state_d   = CMD;
          bit_cnt_d = '0;
        end
      end
      CMD: begin
        if (sclk_rise) begin
          sh_d = shin;
          if (bit_cnt_q == 7'd7) begin
            if (shin[7:0] == CMD_RD ||
                shin[7:0] == CMD_WR) begin
              wr_d    = (shin[7:0] == CMD_WR);
              state_d = ADDR;
            end else begin
              err_d   = 1'b1;
              state_d = WAIT;
            end
          end
        end
      end
      ADDR: begin
        if (sclk_rise) begin
          sh_d = shin;
          if (bit_cnt_q == 7'd39) begin
            addr_d = shin;
            if (wr_q) begin
              state_d = WDATA;
            end else begin
              cs_d    = 1'b1;
              state_d = DUMMY;
            end
          end
        end
      end
      WDATA: begin
        if (sclk_rise) begin
          sh_d = shin;
          if (bit_cnt_q == 7'd71) begin
            wdata_d = shin;
            cs_d    = 1'b1;
            state_d = DUMMY;
          end
        end
      end
      DUMMY: begin
        if (sclk_rise) begin
          if (wr_q && bit_cnt_q == 7'd79)
            state_d = WAIT;
          if (!wr_q && bit_cnt_q == 7'd47) begin
            state_d = RDATA;
            if (cs_q && !reg_ack) begin
              sh_d  = '0;
              err_d = 1'b1;
            end
          end
        end
      end
      RDATA: begin
        // First fall after entry precedes the master's first sample
        if (sclk_fall && bit_cnt_q > 7'd48)
          sh_d = {sh_q[30:0], 1'b0};
        if (sclk_rise && bit_cnt_q == 7'd79)
          state_d = WAIT;
      end
      WAIT: ;
      default: state_d = IDLE;
    endcase

    if (ssn_rise)
      state_d = IDLE;
  end

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cs_q      <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      be_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cs_q      <= cs_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      be_q      <= be_d;
    end
  end

  assign sdout     = (state_q == RDATA) & sh_q[31];
  assign reg_cs    = cs_q;
  assign reg_wr    = wr_q;
  assign reg_addr  = addr_q;
  assign reg_be    = be_q;
  assign reg_wdata = wdata_q;
  assign spi_err   = err_q;

endmodule
